// File: rtl/instr_step_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module : riscv_pkg
// Brief  : Opcode constants, NOP word and fetch FSM states shared by the fetch stage.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [31:0] NOP_WORD = 32'h00000013;

   // ST_ prefix keeps the state names clear of the LOAD opcode constant.
   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_PACE    = 2'd2
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_step_fetch_if.sv
//------------------------------------------------------------------------------
// Module : instr_step_fetch_if
// Brief  : Instruction word valid/ready handshake plus wrap pulse.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_step_fetch_if;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid;
   logic        instr_ready;
   logic        wrap_o;

   modport master (
      output instr_o,
      output pc_o,
      output instr_valid,
      output wrap_o,
      input  instr_ready
   );

   modport slave (
      input  instr_o,
      input  pc_o,
      input  instr_valid,
      input  wrap_o,
      output instr_ready
   );
endinterface

`default_nettype wire

// File: rtl/instr_step_fetch_rom.sv
//------------------------------------------------------------------------------
// Module : instr_rom
// Brief  : DEPTH x 32 synchronous-read ROM, one sample word per opcode class.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_rom
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] addr,
   output logic [31:0]              data
);

   function automatic logic [31:0] rom_word(input int unsigned a);
      logic [31:0] w;
      case (a)
         0:       w = 32'h003100B3;
         1:       w = 32'h00510093;
         2:       w = 32'h00312423;
         3:       w = 32'h00412083;
         4:       w = 32'h00208463;
         5:       w = 32'h010000EF;
         6:       w = 32'h000100E7;
         7:       w = 32'h123450B7;
         8:       w = 32'h00001097;
         default: w = NOP_WORD;
      endcase
      return w;
   endfunction

   always_ff @(posedge clk) begin
      data <= rom_word(32'(addr));
   end

endmodule

`default_nettype wire

// File: rtl/instr_step_fetch.sv
//------------------------------------------------------------------------------
// Module : instr_step_fetch
// Brief  : Paced ROM instruction source, advancing on a delay tick or step pulse.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_step_fetch
   import riscv_pkg::*;
#(
   parameter int unsigned DELAY_COUNT = 50_000_000,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned LAST_IDX    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  step,
   instr_step_fetch_if.master    bus
);

   localparam int unsigned CW = $clog2(DELAY_COUNT + 1);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_COUNT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(LAST_IDX);

   fetch_state_e  state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pc_q, pc_d;
   logic          valid_q, valid_d;
   logic          wrap_q, wrap_d;
   logic [IW-1:0] rom_addr;
   logic [31:0]   rom_data;

   // The ROM is addressed with the next index so its registered output
   // already holds the word for idx_q throughout the LOAD cycle.
   assign rom_addr = rst ? '0 : idx_d;

   instr_rom #(.DEPTH(DEPTH)) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            instr_d = rom_data;
            pc_d    = 32'({idx_q, 2'b00});
            valid_d = 1'b1;
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (bus.instr_ready) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_PACE;
            end
         end
         ST_PACE: begin
            if ((run && (cnt_q == CNT_LAST)) || step) begin
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
               wrap_d  = (idx_q == IDX_LAST);
               state_d = ST_LOAD;
            end else if (run) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         cnt_q   <= '0;
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.instr_o     = instr_q;
   assign bus.pc_o        = pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.wrap_o      = wrap_q;

endmodule

`default_nettype wire
